lsq_mem_sched: RTL

LSQ_MEM_SCHED -- requirements
Module: lsq_mem_sched

---
 rtl/lsq_mem_sched.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/lsq_mem_sched.sv
// Load/store queue memory scheduler: issues one LSQ head entry at a time to memory,
// then returns load data over the CDB. Flushes never abandon an in-flight memory access.
module lsq_mem_sched #(
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        nreset,

    input  logic        lsq_ready,
    input  logic        lsq_opcode,
    input  logic [31:0] lsq_addr,
    input  logic [31:0] lsq_wdata,
    input  logic [4:0]  lsq_rd_tag,
    output logic        lsq_issue,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,

    output logic        cdb_req,
    output logic [4:0]  cdb_req_tag,
    output logic [31:0] cdb_req_data,
    input  logic        cdb_gnt,

    input  logic        flush_valid,
    output logic        store_done,
    output logic        busy,
    output logic        align_err,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEM   = 2'd1,
        CDB   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(ACK_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [4:0]  rd_tag_q, rd_tag_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;

    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        cdb_req_q, cdb_req_d;
    logic [4:0]  cdb_req_tag_q, cdb_req_tag_d;
    logic [31:0] cdb_req_data_q, cdb_req_data_d;
    logic        store_done_q, store_done_d;
    logic        busy_q, busy_d;
    logic        align_err_q, align_err_d;
    logic        timeout_err_q, timeout_err_d;

    assign lsq_issue = lsq_ready & (state_q == IDLE) & ~flush_valid;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d        = state_q;
        is_store_d     = is_store_q;
        rd_tag_d       = rd_tag_q;
        wait_cnt_d     = wait_cnt_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        cdb_req_tag_d  = cdb_req_tag_q;
        cdb_req_data_d = cdb_req_data_q;
        store_done_d   = 1'b0;
        align_err_d    = align_err_q;
        timeout_err_d  = timeout_err_q;

        case (state_q)
            IDLE: begin
                if (lsq_issue) begin
                    if (lsq_addr[1:0] != 2'b00) begin
                        // Misaligned entries are consumed without touching memory.
                        align_err_d = 1'b1;
                    end else begin
                        is_store_d  = lsq_opcode;
                        rd_tag_d    = lsq_rd_tag;
                        mem_addr_d  = lsq_addr;
                        mem_wdata_d = lsq_wdata;
                        wait_cnt_d  = 8'd0;
                        state_d     = MEM;
                    end
                end
            end
            MEM, DRAIN: begin
                // Ack beats the timeout threshold; the threshold beats a flush.
                if (mem_ack) begin
                    state_d = IDLE;
                    if (state_q == MEM && !flush_valid) begin
                        if (is_store_q) begin
                            store_done_d = 1'b1;
                        end else begin
                            cdb_req_data_d = mem_rdata;
                            cdb_req_tag_d  = rd_tag_q;
                            state_d        = CDB;
                        end
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                    if (state_q == MEM && flush_valid) begin
                        state_d = DRAIN;
                    end
                end
            end
            CDB: begin
                if (cdb_gnt || flush_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Registered outputs follow the state being entered.
        mem_req_d = (state_d == MEM) || (state_d == DRAIN);
        mem_we_d  = mem_req_d & is_store_d;
        cdb_req_d = (state_d == CDB);
        busy_d    = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q        <= IDLE;
            is_store_q     <= 1'b0;
            rd_tag_q       <= 5'd0;
            wait_cnt_q     <= 8'd0;
            mem_req_q      <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= 32'd0;
            mem_wdata_q    <= 32'd0;
            cdb_req_q      <= 1'b0;
            cdb_req_tag_q  <= 5'd0;
            cdb_req_data_q <= 32'd0;
            store_done_q   <= 1'b0;
            busy_q         <= 1'b0;
            align_err_q    <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            is_store_q     <= is_store_d;
            rd_tag_q       <= rd_tag_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_req_q      <= mem_req_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            cdb_req_q      <= cdb_req_d;
            cdb_req_tag_q  <= cdb_req_tag_d;
            cdb_req_data_q <= cdb_req_data_d;
            store_done_q   <= store_done_d;
            busy_q         <= busy_d;
            align_err_q    <= align_err_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign cdb_req      = cdb_req_q;
    assign cdb_req_tag  = cdb_req_tag_q;
    assign cdb_req_data = cdb_req_data_q;
    assign store_done   = store_done_q;
    assign busy         = busy_q;
    assign align_err    = align_err_q;
    assign timeout_err  = timeout_err_q;

endmodule
